// File: rtl/iram_loader.sv
// iram_loader: 128x16 writable instruction RAM with a byte-stream loader.
//
// A host opens a session with LD_START, streams program bytes high byte
// first, and closes it with LD_DONE. Each byte pair becomes one 16-bit
// word, written at the next sequential word address. The CPU reads
// through a combinational port addressed by byte address.
//
// Optional feature macro: IRAM_LOADER_CKSUM_EN
//   When defined, LD_DONE is followed by one checksum byte. The session
//   ends with ERR set if the 8-bit sum of all data bytes plus the
//   checksum byte is not zero.
//
// Ports:
//   CLK       in   clock, rising edge
//   RESET     in   asynchronous active-low reset
//   ADDR[7:0] in   CPU byte address; word index is ADDR[7:1]
//   Q[15:0]   out  CPU read data, mem[ADDR[7:1]] (combinational)
//   LD_START  in   pulse, opens or restarts a load session
//   LD_VALID  in   LD_DATA valid
//   LD_DATA   in   program byte
//   LD_READY  out  byte accepted when LD_VALID & LD_READY
//   LD_DONE   in   pulse, closes the session
//   HOLD      out  high while a session is open (keep CPU stalled)
//   WCOUNT    out  words written in the current/last session
//   ERR       out  sticky session error
//   OK        out  last session closed without error
//
// State | Meaning
// IDLE  | no session open, loader not ready
// HI    | waiting for the high byte of the next word
// LO    | high byte latched, waiting for the low byte
// FULL  | all DEPTH words written; further bytes are dropped with ERR
// CHK   | (checksum build only) waiting for the checksum byte

module iram_loader #(
    parameter int DEPTH = 128,
    parameter int DW    = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  ADDR,
    output logic [15:0] Q,
    input  logic        LD_START,
    input  logic        LD_VALID,
    input  logic [7:0]  LD_DATA,
    output logic        LD_READY,
    input  logic        LD_DONE,
    output logic        HOLD,
    output logic [7:0]  WCOUNT,
    output logic        ERR,
    output logic        OK
);

    localparam logic [7:0] LAST_WORD = 8'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
`ifdef IRAM_LOADER_CKSUM_EN
        S_FULL,
        S_CHK
`else
        S_FULL
`endif
    } state_t;

    state_t state, state_nxt;

    logic [DW-1:0] mem [DEPTH];
    logic [6:0]    ptr;
    logic [7:0]    wcount;
    logic [7:0]    hi_byte;
    logic          err;
    logic          ok;

    logic latch_hi;
    logic do_write;
    logic set_err;
    logic close;

`ifdef IRAM_LOADER_CKSUM_EN
    logic [7:0] sum;
    logic [7:0] cks_total;
    logic       sum_add;
`endif

    // ADDR[0] selects a byte within a word; the fetch port is word-wide.
    logic addr_lsb_unused;
    assign addr_lsb_unused = ADDR[0];

    always_comb begin
        state_nxt = state;
        latch_hi  = 1'b0;
        do_write  = 1'b0;
        set_err   = 1'b0;
        close     = 1'b0;
`ifdef IRAM_LOADER_CKSUM_EN
        cks_total = sum + LD_DATA;
        sum_add   = 1'b0;
`endif
        if (LD_START) begin
            // Restart wins; a byte in the same cycle is ignored.
            state_nxt = S_HI;
        end else begin
            case (state)
                S_HI: begin
                    if (LD_VALID) begin
                        latch_hi  = 1'b1;
                        state_nxt = S_LO;
`ifdef IRAM_LOADER_CKSUM_EN
                        sum_add   = 1'b1;
`endif
                    end
                end
                S_LO: begin
                    if (LD_VALID) begin
                        do_write  = 1'b1;
                        state_nxt = (wcount == LAST_WORD) ? S_FULL : S_HI;
`ifdef IRAM_LOADER_CKSUM_EN
                        sum_add   = 1'b1;
`endif
                    end
                end
                S_FULL: begin
                    if (LD_VALID) begin
                        set_err = 1'b1;
`ifdef IRAM_LOADER_CKSUM_EN
                        sum_add = 1'b1;
`endif
                    end
                end
`ifdef IRAM_LOADER_CKSUM_EN
                S_CHK: begin
                    if (LD_VALID) begin
                        if (cks_total != 8'd0) set_err = 1'b1;
                        close     = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
`endif
                default: ;
            endcase

            // Any same-cycle byte is consumed first; if that still leaves a
            // half-assembled word, the high byte is dropped as an error.
`ifdef IRAM_LOADER_CKSUM_EN
            if (LD_DONE && state != S_IDLE && state != S_CHK) begin
                if (state_nxt == S_LO) set_err = 1'b1;
                state_nxt = S_CHK;
            end
`else
            if (LD_DONE && state != S_IDLE) begin
                if (state_nxt == S_LO) set_err = 1'b1;
                state_nxt = S_IDLE;
                close     = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= S_IDLE;
            ptr     <= 7'd0;
            wcount  <= 8'd0;
            hi_byte <= 8'd0;
            err     <= 1'b0;
            ok      <= 1'b0;
`ifdef IRAM_LOADER_CKSUM_EN
            sum     <= 8'd0;
`endif
        end else begin
            state <= state_nxt;
            if (LD_START) begin
                ptr    <= 7'd0;
                wcount <= 8'd0;
                err    <= 1'b0;
                ok     <= 1'b0;
`ifdef IRAM_LOADER_CKSUM_EN
                sum    <= 8'd0;
`endif
            end else begin
                if (latch_hi) hi_byte <= LD_DATA;
                if (do_write) begin
                    // Wraps to 0 after the last word, but FULL blocks writes.
                    ptr    <= ptr + 7'd1;
                    wcount <= wcount + 8'd1;
                end
                if (set_err) err <= 1'b1;
                if (close)   ok  <= ~(err | set_err);
`ifdef IRAM_LOADER_CKSUM_EN
                if (sum_add) sum <= sum + LD_DATA;
`endif
            end
        end
    end

    // RAM contents survive reset so a loaded program outlives a CPU reset.
    always_ff @(posedge CLK) begin
        if (do_write) mem[ptr] <= {hi_byte, LD_DATA};
    end

    assign Q        = mem[ADDR[7:1]];
    assign HOLD     = (state != S_IDLE);
    assign LD_READY = (state != S_IDLE);
    assign WCOUNT   = wcount;
    assign ERR      = err;
    assign OK       = ok;

endmodule

// File: tb/tb_iram_loader.sv
module tb_iram_loader;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  ADDR;
    logic [15:0] Q;
    logic        LD_START;
    logic        LD_VALID;
    logic [7:0]  LD_DATA;
    logic        LD_READY;
    logic        LD_DONE;
    logic        HOLD;
    logic [7:0]  WCOUNT;
    logic        ERR;
    logic        OK;

    iram_loader dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .ADDR     (ADDR),
        .Q        (Q),
        .LD_START (LD_START),
        .LD_VALID (LD_VALID),
        .LD_DATA  (LD_DATA),
        .LD_READY (LD_READY),
        .LD_DONE  (LD_DONE),
        .HOLD     (HOLD),
        .WCOUNT   (WCOUNT),
        .ERR      (ERR),
        .OK       (OK)
    );

    always #5 CLK = ~CLK;

    localparam int SEL_Q     = 0;
    localparam int SEL_WCNT  = 1;
    localparam int SEL_ERR   = 2;
    localparam int SEL_OK    = 3;
    localparam int SEL_HOLD  = 4;
    localparam int SEL_READY = 5;

    typedef struct {
        int          sel;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    logic obs_req = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] tb_sum;

    // Monitor: pops one expectation per observation strobe.
    always @(negedge CLK) begin
        if (obs_req) begin
            exp_t e;
            logic [15:0] act;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard: observation with empty queue, got none required one");
            end else begin
                e = exp_q.pop_front();
                case (e.sel)
                    SEL_Q:     act = Q;
                    SEL_WCNT:  act = {8'd0, WCOUNT};
                    SEL_ERR:   act = {15'd0, ERR};
                    SEL_OK:    act = {15'd0, OK};
                    SEL_HOLD:  act = {15'd0, HOLD};
                    default:   act = {15'd0, LD_READY};
                endcase
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h required %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input int sel, input logic [15:0] exp, input string name);
        exp_t e;
        e.sel = sel; e.exp = exp; e.name = name;
        exp_q.push_back(e);
        obs_req = 1'b1;
        @(negedge CLK);
        #1;
        obs_req = 1'b0;
    endtask

    task automatic check_q(input logic [7:0] a, input logic [15:0] exp, input string name);
        ADDR = a;
        check(SEL_Q, exp, name);
    endtask

    task automatic start();
        LD_START = 1'b1;
        tick();
        LD_START = 1'b0;
        tb_sum = 8'd0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        LD_VALID = 1'b1;
        LD_DATA  = b;
        tick();
        LD_VALID = 1'b0;
        tb_sum = tb_sum + b;
    endtask

    // Closes the session; the checksum build also sends a correct checksum.
    task automatic close_session();
        LD_DONE = 1'b1;
        tick();
        LD_DONE = 1'b0;
`ifdef IRAM_LOADER_CKSUM_EN
        send_byte(8'(8'd0 - tb_sum));
`endif
    endtask

    initial begin
        RESET = 1'b0; ADDR = 8'd0; LD_START = 1'b0; LD_VALID = 1'b0;
        LD_DATA = 8'd0; LD_DONE = 1'b0; tb_sum = 8'd0;
        repeat (3) tick();

        check(SEL_HOLD,  16'd0, "rst_hold");
        check(SEL_READY, 16'd0, "rst_ready");
        check(SEL_WCNT,  16'd0, "rst_wcount");
        check(SEL_ERR,   16'd0, "rst_err");
        check(SEL_OK,    16'd0, "rst_ok");
        RESET = 1'b1;
        tick();

        // Basic two-word load
        start();
        check(SEL_HOLD,  16'd1, "t1_hold_open");
        check(SEL_READY, 16'd1, "t1_ready_open");
        send_byte(8'h12);
        send_byte(8'h34);
        check_q(8'd0, 16'h1234, "t1_q0_next_cycle");
        send_byte(8'hAB);
        send_byte(8'hCD);
        close_session();
        check(SEL_HOLD, 16'd0, "t1_hold_closed");
        check_q(8'd0, 16'h1234, "t1_q_addr0");
        check_q(8'd1, 16'h1234, "t1_q_addr1");
        check_q(8'd2, 16'hABCD, "t1_q_addr2");
        check_q(8'd3, 16'hABCD, "t1_q_addr3");
        check(SEL_WCNT, 16'd2, "t1_wcount");
        check(SEL_OK,   16'd1, "t1_ok");
        check(SEL_ERR,  16'd0, "t1_err");

        // LD_DONE in IDLE is ignored
        LD_DONE = 1'b1; tick(); LD_DONE = 1'b0;
        check(SEL_HOLD, 16'd0, "idle_done_hold");
        check(SEL_OK,   16'd1, "idle_done_ok");

        // Fill all 128 words, then overflow by one byte
        start();
        for (int i = 0; i < 128; i++) begin
            send_byte(8'(i));
            send_byte(~8'(i));
        end
        check(SEL_WCNT, 16'd128, "t2_wcount_full");
        check(SEL_ERR,  16'd0,   "t2_err_before_extra");
        check(SEL_READY, 16'd1,  "t2_ready_full");
        send_byte(8'hEE);
        check(SEL_ERR,  16'd1,   "t2_err_extra");
        check(SEL_WCNT, 16'd128, "t2_wcount_after_extra");
        close_session();
        check(SEL_OK,   16'd0,   "t2_ok");
        check(SEL_HOLD, 16'd0,   "t2_hold");
        check_q(8'd0,   16'h00FF, "t2_mem0_kept");
        check_q(8'd128, 16'h40BF, "t2_mem64");
        check_q(8'd254, 16'h7F80, "t2_mem127");

        // Dangling high byte
        start();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        close_session();
        check(SEL_WCNT, 16'd1, "t3_wcount");
        check_q(8'd0, 16'h0102, "t3_mem0");
        check_q(8'd2, 16'h0203 ^ 16'h0203 ^ 16'h40FE ^ 16'h40FE ^ 16'h01FE, "t3_mem1_kept");
        check(SEL_ERR, 16'd1, "t3_err");
        check(SEL_OK,  16'd0, "t3_ok");

        // LD_VALID held high across IDLE, mid-session restart in LO
        LD_VALID = 1'b1; LD_DATA = 8'h99;
        tick();
        check(SEL_READY, 16'd0, "t4_ready_idle");
        check(SEL_WCNT,  16'd1, "t4_idle_byte_ignored");
        LD_START = 1'b1; LD_DATA = 8'h77;
        tick();
        LD_START = 1'b0;
        LD_DATA = 8'hAA;
        tick();
        check(SEL_WCNT, 16'd0, "t4_after_hi");
        LD_START = 1'b1; LD_DATA = 8'hBB;
        tick();
        LD_START = 1'b0;
        tb_sum = 8'd0;
        LD_DATA = 8'h55; tick(); tb_sum = tb_sum + 8'h55;
        LD_DATA = 8'h66; tick(); tb_sum = tb_sum + 8'h66;
        LD_VALID = 1'b0;
        check(SEL_WCNT, 16'd1, "t4_wcount");
        check_q(8'd0, 16'h5566, "t4_mem0");
        close_session();
        check(SEL_OK,  16'd1, "t4_ok");
        check(SEL_ERR, 16'd0, "t4_err");

        // Async reset mid-session
        start();
        send_byte(8'h77);
        send_byte(8'h88);
        send_byte(8'h44);
        check(SEL_WCNT, 16'd1, "t5_wcount_pre");
        #2 RESET = 1'b0;
        #1;
        check(SEL_HOLD,  16'd0, "t5_rst_hold");
        check(SEL_READY, 16'd0, "t5_rst_ready");
        check(SEL_WCNT,  16'd0, "t5_rst_wcount");
        check(SEL_ERR,   16'd0, "t5_rst_err");
        check(SEL_OK,    16'd0, "t5_rst_ok");
        check_q(8'd0, 16'h7788, "t5_mem0_retained");
        RESET = 1'b1;
        tick();

`ifdef IRAM_LOADER_CKSUM_EN
        // Checksum: 10 + 20 + D0 = 0 mod 256
        start();
        send_byte(8'h10);
        send_byte(8'h20);
        LD_DONE = 1'b1; tick(); LD_DONE = 1'b0;
        check(SEL_HOLD,  16'd1, "t6_chk_hold");
        check(SEL_READY, 16'd1, "t6_chk_ready");
        send_byte(8'hD0);
        check(SEL_HOLD, 16'd0, "t6_good_hold");
        check(SEL_OK,   16'd1, "t6_good_ok");
        check(SEL_ERR,  16'd0, "t6_good_err");
        start();
        send_byte(8'h10);
        send_byte(8'h20);
        LD_DONE = 1'b1; tick(); LD_DONE = 1'b0;
        send_byte(8'hD1);
        check(SEL_ERR, 16'd1, "t6_bad_err");
        check(SEL_OK,  16'd0, "t6_bad_ok");
`endif

        repeat (2) tick();
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/iram_loader.md
Name: iram_loader

Overview:
- Writable 128x16 instruction RAM plus a byte-stream loader that fills it at run time, replacing the reset-time program image.
- A host streams program bytes, high byte first. The loader assembles each pair into a 16-bit word and writes it at a sequential word address.
- The CPU fetch port keeps the existing byte-addressed read interface: ADDR[7:1] selects the word.
- HOLD keeps the CPU in reset/stall while a load session is active.

Parameters:
- DEPTH, 128, number of 16-bit words; word address width is 7.
- DW, 16, instruction word width; fixed at 16, stream is 2 bytes per word.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- ADDR  input  8  CPU fetch byte address; word index = ADDR[7:1], ADDR[0] ignored.
- Q  output  16  CPU fetch data, combinational read of mem[ADDR[7:1]].
- LD_START  input  1  one-cycle pulse; opens a load session.
- LD_VALID  input  1  LD_DATA valid this cycle.
- LD_DATA  input  8  program byte.
- LD_READY  output  1  loader accepts a byte when LD_VALID & LD_READY.
- LD_DONE  input  1  one-cycle pulse; closes the session.
- HOLD  output  1  high while a session is open.
- WCOUNT  output  8  words written in the current/last session, 0..128.
- ERR  output  1  sticky session error.
- OK  output  1  last session closed without error.

Behaviour:
- Reset (RESET=0, async): state IDLE, HOLD=0, LD_READY=0, WCOUNT=0, ERR=0, OK=0, word pointer=0, byte latch=0. RAM contents are not reset.
- States: IDLE, HI (awaiting high byte), LO (awaiting low byte), FULL.
- LD_READY=1 in HI, LO and FULL; 0 in IDLE. HOLD=1 in any state except IDLE.
- LD_START (any state): next state HI; pointer, WCOUNT, ERR and OK cleared. Any byte presented in the same cycle is ignored. Restarting mid-session abandons the previous session; words already written stay in RAM.
- HI + accepted byte: latch it as the high byte, go to LO.
- LO + accepted byte: write {latched high byte, LD_DATA} to mem[pointer] on that edge; pointer+1, WCOUNT+1. Next state HI, or FULL if WCOUNT reaches DEPTH.
- FULL + accepted byte: byte discarded, ERR set. No wrap-around; mem[0] is never overwritten.
- Same-cycle LD_VALID and LD_DONE: the byte is consumed first, then the session closes.
- LD_DONE in state LO, after any same-cycle byte: the dangling high byte is discarded and ERR is set.
- LD_DONE in IDLE: ignored.
- On close: state IDLE, HOLD=0, OK = ~ERR. WCOUNT and ERR hold until the next LD_START.
- Latency:
  - Written word is visible on Q for a matching ADDR in the cycle after the write edge.
  - HOLD falls on the edge that samples LD_DONE.
- Read and write of the same word in one cycle: Q shows the old data.
- The Q read port is always live, including during a load; the CPU should ignore Q while HOLD=1.

Optional Feature:
- Macro IRAM_LOADER_CKSUM_EN.
- When defined:
  - An 8-bit running sum of all accepted data bytes is kept and cleared by LD_START.
  - LD_DONE moves to an added state CHK (HOLD=1, LD_READY=1).
  - The next accepted byte is the checksum. If the 8-bit sum of data bytes plus checksum byte is nonzero, ERR is set. The FSM then goes to IDLE and OK = ~ERR.
  - LD_START in CHK restarts as normal.
- When not defined: no CHK state and no sum register; LD_DONE closes the session directly.

Test Plan:
- Reset, then LD_START, stream 12 34 AB CD, LD_DONE -> ADDR=0 gives Q=1234, ADDR=2 gives Q=ABCD, ADDR=3 gives Q=ABCD, WCOUNT=2, OK=1, ERR=0, HOLD=0.
- Stream 256 bytes (128 words), then 1 extra byte -> WCOUNT=128, extra byte accepted and dropped, ERR=1, mem[0] unchanged, OK=0 after LD_DONE.
- Stream 3 bytes 01 02 03, LD_DONE -> WCOUNT=1, mem[0]=0102, ERR=1, OK=0.
- LD_VALID held high with LD_READY toggling; LD_START during LO -> pointer resets, next two bytes 55 66 land at mem[0]=5566, WCOUNT=1.
- RESET asserted mid-session (after 1 word) -> HOLD, LD_READY, WCOUNT, ERR and OK all 0 immediately (async); mem[0] retains the written word.
- CKSUM_EN defined: bytes 10 20, LD_DONE, checksum D0 -> OK=1; repeat with checksum D1 -> ERR=1, OK=0.
